// File: rtl/pmem_arbiter_if.sv
// Bundle of the icache, dcache and pmem signals seen by the pmem arbiter.
// The slave modport is the arbiter's view; master is the caches/pmem side.
interface pmem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic              i_read;
    logic [31:0]       i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [31:0]       d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one 64-bit pmem port between icache and dcache,
// moving each 256-bit line as a 4-beat burst and pulsing a one-cycle resp.
module pmem_arbiter #(
    parameter int LINE_W   = 256,
    parameter int BEAT_W   = 64,
    parameter int OFFSET_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    pmem_arbiter_if.slave bus
);
    localparam int BURST_LEN = LINE_W / BEAT_W;
    localparam int CNT_W     = $clog2(BURST_LEN);

    typedef enum logic [2:0] {IDLE, I_READ, D_READ, D_WRITE, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_beat;
    logic              r_last_data;
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_line;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic              r_i_resp;
    logic              r_d_resp;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_in_burst;
    logic              w_is_read;
    logic              w_beat_ok;
    logic              w_last_beat;
    logic [LINE_W-1:0] w_line_upd;

    assign w_i_req     = bus.i_read;
    assign w_d_req     = bus.d_read | bus.d_write;
    assign w_is_read   = (r_state == I_READ) || (r_state == D_READ);
    assign w_in_burst  = w_is_read || (r_state == D_WRITE);
    assign w_beat_ok   = w_in_burst && bus.pmem_resp;
    assign w_last_beat = (r_beat == CNT_W'(BURST_LEN - 1));

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (w_i_req && (!w_d_req || r_last_data)) begin
                    w_grant_i = 1'b1;
                    w_next    = I_READ;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                    w_next    = bus.d_write ? D_WRITE : D_READ;
                end
            end
            I_READ, D_READ, D_WRITE: begin
                if (bus.pmem_resp && w_last_beat) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_line_upd = r_line;
        w_line_upd[int'(r_beat)*BEAT_W +: BEAT_W] = bus.pmem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_last_data  <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_line       <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_pmem_read  <= (w_next == I_READ) || (w_next == D_READ);
            r_pmem_write <= (w_next == D_WRITE);
            r_i_resp     <= (w_next == DONE) && (r_state == I_READ);
            r_d_resp     <= (w_next == DONE) && ((r_state == D_READ) || (r_state == D_WRITE));
            if (w_grant_i) begin
                r_last_data <= 1'b0;
                r_addr      <= {bus.i_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            if (w_grant_d) begin
                r_last_data <= 1'b1;
                r_addr      <= {bus.d_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                r_wdata     <= bus.d_wdata;
            end
            if (w_beat_ok) begin
                r_beat <= w_last_beat ? '0 : r_beat + CNT_W'(1);
                if (w_is_read) r_line <= w_line_upd;
                // The assembled line is published only when the burst finishes.
                if (w_last_beat && (r_state == I_READ)) r_i_rdata <= w_line_upd;
                if (w_last_beat && (r_state == D_READ)) r_d_rdata <= w_line_upd;
            end
        end
    end

    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.i_resp       = r_i_resp;
    assign bus.d_resp       = r_d_resp;
    assign bus.pmem_read    = r_pmem_read;
    assign bus.pmem_write   = r_pmem_write;
    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = r_wdata[int'(r_beat)*BEAT_W +: BEAT_W];
endmodule
